// File: rtl/dvi_timing_gen.sv
// dvi_timing_gen: raster timing generator that pulls pixels from a ready/valid source during active video
// and drives registered DVI-style sync, data enable and pixel data.
module dvi_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP = 40,
  parameter int H_SYNC = 128,
  parameter int H_BP = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP = 1,
  parameter int V_SYNC = 4,
  parameter int V_BP = 23,
  parameter bit SYNC_POL = 1'b1,
  parameter logic [23:0] FILL_COLOR = 24'h000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] Video,
  input  logic        VideoValid,
  output logic        VideoReady,
  output logic [23:0] DVIData,
  output logic        DVIDE,
  output logic        DVIHSync,
  output logic        DVIVSync,
  output logic        FrameStart,
  output logic        Underflow
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  logic [HW-1:0] hCount;
  logic [VW-1:0] vCount;
  logic active, hWrap, vWrap, hSyncOn, vSyncOn;
  always_comb begin
    active = (hCount < H_ACT) && (vCount < V_ACT);
    hWrap = hCount == H_LAST;
    vWrap = vCount == V_LAST;
    hSyncOn = (hCount >= H_SYNC_START) && (hCount < H_SYNC_END);
    vSyncOn = (vCount >= V_SYNC_START) && (vCount < V_SYNC_END);
    VideoReady = active && !reset;
  end
  // A missing pixel is filled but not skipped, so the stream stays count-aligned rather than position-aligned.
  always_ff @(posedge clock) begin
    if (reset) begin
      hCount <= '0;
      vCount <= '0;
      DVIData <= '0;
      DVIDE <= 1'b0;
      DVIHSync <= !SYNC_POL;
      DVIVSync <= !SYNC_POL;
      FrameStart <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      hCount <= hWrap ? '0 : hCount + HW'(1);
      vCount <= hWrap ? (vWrap ? '0 : vCount + VW'(1)) : vCount;
      DVIData <= !active ? '0 : VideoValid ? Video : FILL_COLOR;
      DVIDE <= active;
      DVIHSync <= hSyncOn ? SYNC_POL : !SYNC_POL;
      DVIVSync <= vSyncOn ? SYNC_POL : !SYNC_POL;
      FrameStart <= (hCount == '0) && (vCount == '0);
      Underflow <= Underflow | (active && !VideoValid);
    end
  end
endmodule

// File: tb/tb_dvi_timing_gen.sv
// tb_dvi_timing_gen: scaled-raster bench; the driver pushes expected outputs into a queue and a monitor
// pops and compares them one cycle later, plus directed frame/line timing checks.
module tb_dvi_timing_gen;
  localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam bit POL = 1'b1;
  localparam logic [23:0] FILL = 24'hABCDEF;

  typedef struct packed {
    logic rst;
    logic [23:0] data;
    logic de, hs, vs, fs, uf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [23:0] Video = '0;
  logic VideoValid = 1'b0;
  logic VideoReady, DVIDE, DVIHSync, DVIVSync, FrameStart, Underflow;
  logic [23:0] DVIData;

  int total = 0, passed = 0;
  exp_t q[$];
  int mx = 0, my = 0, src = 0;
  bit muf = 0;

  dvi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(POL), .FILL_COLOR(FILL)
  ) dut (
    .clock(clk), .reset(reset), .Video(Video), .VideoValid(VideoValid),
    .VideoReady(VideoReady), .DVIData(DVIData), .DVIDE(DVIDE),
    .DVIHSync(DVIHSync), .DVIVSync(DVIVSync), .FrameStart(FrameStart),
    .Underflow(Underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input int k);
    logic [31:0] kk;
    kk = k;
    return {kk[7:0], 8'hCC, 8'(k * 3)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  // One driven cycle: inputs set at the falling edge, expected post-edge outputs pushed to the queue.
  task automatic step(input bit r, input bit hole);
    exp_t e;
    bit act, v;
    act = (mx < HA) && (my < VA);
    v = r ? 1'b1 : act ? !hole : 1'($urandom_range(0, 1));
    @(negedge clk);
    reset = r;
    VideoValid = v;
    Video = pix(src);
    #1;
    chk("ready", {31'b0, VideoReady}, {31'b0, act && !r});
    if (r) begin
      e.rst = 1'b1; e.data = '0; e.de = 1'b0; e.hs = !POL; e.vs = !POL; e.fs = 1'b0; e.uf = 1'b0;
      mx = 0; my = 0; muf = 0; src = 0;
    end else begin
      muf = muf | (act && !v);
      e.rst = 1'b0;
      e.data = !act ? 24'h0 : v ? pix(src) : FILL;
      e.de = act;
      e.hs = (mx >= HA + HFP && mx < HA + HFP + HS) ? POL : !POL;
      e.vs = (my >= VA + VFP && my < VA + VFP + VS) ? POL : !POL;
      e.fs = (mx == 0) && (my == 0);
      e.uf = muf;
      if (act && v) src++;
      mx++;
      if (mx == HT) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end
    end
    q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // Monitor: scoreboard compare plus directed timing checks on the raw outputs.
  initial begin : monitor
    exp_t e;
    int cyc = 0, prevFs = -1, deCnt = 0, hsRun = 0, vsRun = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out", {3'b0, DVIData, DVIDE, DVIHSync, DVIVSync, FrameStart, Underflow},
                   {3'b0, e.data, e.de, e.hs, e.vs, e.fs, e.uf});
        if (e.rst) begin
          prevFs = -1; deCnt = 0; hsRun = 0; vsRun = 0;
        end else begin
          if (FrameStart === 1'b1) begin
            if (prevFs >= 0) begin
              chk("fsPeriod", cyc - prevFs, HT * VT);
              chk("deCount", deCnt, HA * VA);
            end
            prevFs = cyc;
            deCnt = 0;
          end
          deCnt += (DVIDE === 1'b1) ? 1 : 0;
          if (DVIHSync === POL) hsRun++;
          else begin
            if (hsRun != 0) chk("hsWidth", hsRun, HS);
            hsRun = 0;
          end
          if (DVIVSync === POL) vsRun++;
          else begin
            if (vsRun != 0) chk("vsWidth", vsRun, VS * HT);
            vsRun = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit holed;
    repeat (3) step(1'b1, 1'b0);
    run(3 * HT * VT);
    holed = 0;
    for (int i = 0; i < HT * VT; i++) begin
      step(1'b0, !holed && mx == 5 && my == 0);
      if (mx == 6 && my == 0) holed = 1;
    end
    run(3 * HT * VT);
    while (!(mx == 4 && my == 2)) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    run(2 * HT * VT + 5);
    repeat (3) @(posedge clk);
    #2;
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dvi_timing_gen.md
Name: dvi_timing_gen

Overview:
- Sits directly downstream of PatternGenerator (or any 24-bit VideoValid/VideoReady pixel source).
- Pulls raster-order pixels through the ready/valid handshake only during the active video region.
- Drives registered DVI-style timing (HSync, VSync, DE) plus pixel data, default 800x600@60 (40 MHz pixel clock).
- Frame alignment is by count only: exactly H_ACTIVE*V_ACTIVE pixels are consumed per frame; there is no start-of-frame marker.

Parameters:
- H_ACTIVE, 800, active pixels per line
- H_FP, 40, horizontal front porch (cycles)
- H_SYNC, 128, horizontal sync width
- H_BP, 88, horizontal back porch
- V_ACTIVE, 600, active lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 1, sync asserted level (1 = active-high)
- FILL_COLOR, 24'h000000, pixel driven on underflow

Ports:
- clock  in  1  pixel clock
- reset  in  1  synchronous, active-high
- Video  in  24  upstream pixel {R,G,B}
- VideoValid  in  1  upstream pixel valid
- VideoReady  out  1  block accepts a pixel this cycle
- DVIData  out  24  registered output pixel
- DVIDE  out  1  registered data enable
- DVIHSync  out  1  registered horizontal sync
- DVIVSync  out  1  registered vertical sync
- FrameStart  out  1  one-cycle pulse, registered, coincides with first DE of each frame
- Underflow  out  1  sticky error flag

Behaviour:
- One clock; reset is synchronous and active-high.
- Counters:
  - hcount counts 0..H_TOTAL-1, with H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056 by default).
  - vcount counts 0..V_TOTAL-1, with V_TOTAL = 628 by default.
  - hcount wraps to 0 and increments vcount.
  - vcount wraps to 0 at V_TOTAL-1 when hcount wraps.
  - Counter widths are sized by $clog2 of the totals.
- active = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
- VideoReady = active && !reset (combinational from registered counters).
- Accept: a pixel is transferred when VideoReady && VideoValid. Upstream must not change Video while VideoValid is high and VideoReady is low.
- Latency: each output reflects the counter state of the previous cycle.
  - DVIDE(t+1) = active(t).
  - DVIData(t+1) = Video(t) when accepted.
  - DVIData(t+1) = FILL_COLOR on an active slot with VideoValid=0.
  - DVIData(t+1) = 0 outside active.
- HSync is asserted (level SYNC_POL) for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, delayed by one cycle.
- VSync is asserted for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC over whole lines, delayed by one cycle.
- FrameStart(t+1) = 1 when hcount=0 && vcount=0 at time t.
- Underflow:
  - An active slot with VideoValid=0 sets Underflow to 1. Underflow stays set until reset.
  - No pixel is consumed in that slot; the stream is not resynchronised, so downstream picture shifts by one pixel. This is a system error, flagged only.
- Blanking: VideoReady=0; VideoValid is ignored; no pixel is consumed.
- Reset values:
  - hcount=0, vcount=0, DVIData=0, DVIDE=0, FrameStart=0, Underflow=0.
  - DVIHSync=DVIVSync=!SYNC_POL.
  - VideoReady=0 while reset is high.
- Reset mid-frame: counters return to 0 on the next edge; outputs go to reset values the same edge. The first cycle after reset deasserts is pixel (0,0) with VideoReady=1.
- Simultaneous wrap (last pixel of last line): both counters go to 0 on the same edge, and FrameStart pulses one cycle later.

Test Plan:
- Reset released at cycle 0 with PatternGenerator-style source → VideoReady=1 at cycle 0; DVIDE=1 and FrameStart=1 at cycle 1; DVIData=24'h00CC00 at cycle 1.
- Line timing → VideoReady high 800 consecutive cycles then low 256. DVIHSync high for cycles 841..968 relative to line start (128 cycles).
- Frame timing → exactly 480000 accepts per frame. DVIVSync high for lines 601..604. FrameStart period is 663168 cycles.
- Hold VideoValid=0 for one cycle at pixel (5,0) → DVIData=FILL_COLOR at next cycle. Underflow=1 thereafter, still 1 after three frames, cleared only by reset.
- VideoValid toggling during blanking → no accept, DVIDE=0, DVIData=0, Underflow stays 0.
- Assert reset at hcount=400, vcount=10 for one cycle → next cycle all outputs are at reset values. After release the counters restart at (0,0) and FrameStart pulses one cycle later.
